// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds PS/2 set-2 prefix bytes (E0 extended, F0 break)
// into single key events, drops keyboard housekeeping bytes, and queues events
// in a first-word-fall-through FIFO for application logic.
module ps2_scancode_decoder #(
   parameter int unsigned PREFIX_TIMEOUT = 100000,
   parameter int unsigned DEPTH          = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 ps2_data_out,
   input  logic                       pulso_done,
   output logic [7:0]                 ev_code,
   output logic                       ev_ext,
   output logic                       ev_brk,
   output logic                       ev_empty,
   output logic                       ev_full,
   output logic [$clog2(DEPTH):0]     ev_count,
   input  logic                       ev_rd,
   output logic                       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(PREFIX_TIMEOUT);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   logic [1:0]    state;
   logic [TW-1:0] tcnt;
   logic          is_discard;
   logic          is_e0;
   logic          is_f0;
   logic          emit;
   logic [9:0]    emit_word;

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;

   // Classify the incoming byte and form the event word from the prefix state.
   always_comb begin
      is_discard = 1'b0;
      case (ps2_data_out)
         8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_discard = 1'b1;
         default:                                          is_discard = 1'b0;
      endcase
      is_e0     = (ps2_data_out == 8'hE0);
      is_f0     = (ps2_data_out == 8'hF0);
      emit      = pulso_done && !is_discard && !is_e0 && !is_f0;
      emit_word = {(state == ST_EXT) || (state == ST_EXT_BRK),
                   (state == ST_BRK) || (state == ST_EXT_BRK),
                   ps2_data_out};
   end

   // Prefix FSM; a strobe takes priority over the timeout on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else if (pulso_done) begin
         if (is_discard) begin
            state <= ST_IDLE;
         end else if (is_e0) begin
            state <= ST_EXT;
         end else if (is_f0) begin
            case (state)
               ST_IDLE: state <= ST_BRK;
               ST_EXT:  state <= ST_EXT_BRK;
               default: state <= state;
            endcase
         end else begin
            state <= ST_IDLE;
         end
      end else if (state != ST_IDLE && tcnt == TW'(PREFIX_TIMEOUT - 1)) begin
         state <= ST_IDLE;
      end
   end

   // Inter-byte timeout counter; runs only while a prefix is pending.
   always_ff @(posedge clk) begin
      if (reset || pulso_done || state == ST_IDLE) begin
         tcnt <= '0;
      end else if (tcnt == TW'(PREFIX_TIMEOUT - 1)) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + TW'(1);
      end
   end

   assign empty = (count == '0);
   assign full  = (count == (AW + 1)'(DEPTH));
   assign pop   = ev_rd && !empty;
   assign push  = emit && (!full || pop);

   // Event storage; no reset needed since the head is masked while empty.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr] <= emit_word;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (emit && full && !pop) overflow <= 1'b1;
      end
   end

   // Head presentation, forced to zero while the FIFO is empty.
   always_comb begin
      {ev_ext, ev_brk, ev_code} = '0;
      if (!empty) {ev_ext, ev_brk, ev_code} = mem[rd_ptr];
   end

   assign ev_empty = empty;
   assign ev_full  = full;
   assign ev_count = count;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed checks of the scan-code decoder with a
// short prefix timeout (16) and a 4-deep event FIFO.
module tb_ps2_scancode_decoder;

   logic       clk;
   logic       reset;
   logic [7:0] ps2_data_out;
   logic       pulso_done;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_brk;
   logic       ev_empty;
   logic       ev_full;
   logic [2:0] ev_count;
   logic       ev_rd;
   logic       overflow;

   int checks;
   int failures;

   ps2_scancode_decoder #(
      .PREFIX_TIMEOUT(16),
      .DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ps2_data_out(ps2_data_out),
      .pulso_done(pulso_done),
      .ev_code(ev_code),
      .ev_ext(ev_ext),
      .ev_brk(ev_brk),
      .ev_empty(ev_empty),
      .ev_full(ev_full),
      .ev_count(ev_count),
      .ev_rd(ev_rd),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; strobes on the next rising edge, returns at the
   // following falling edge, so back-to-back calls give consecutive strobes.
   task automatic send_byte(input logic [7:0] b);
      ps2_data_out = b;
      pulso_done   = 1'b1;
      @(negedge clk);
      pulso_done   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Check head against {ext, brk, code}, then pop it.
   task automatic pop_check(input string tag, input logic [9:0] exp);
      check({tag, "_nonempty"}, 32'(ev_empty), 32'd0);
      check(tag, 32'({ev_ext, ev_brk, ev_code}), 32'(exp));
      ev_rd = 1'b1;
      @(negedge clk);
      ev_rd = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      ps2_data_out = 8'h00;
      pulso_done   = 1'b0;
      ev_rd        = 1'b0;
      idle(3);
      reset = 1'b0;

      // Reset values
      check("rst_empty", 32'(ev_empty), 32'd1);
      check("rst_full", 32'(ev_full), 32'd0);
      check("rst_count", 32'(ev_count), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_head", 32'({ev_ext, ev_brk, ev_code}), 32'd0);

      // Make / break
      send_byte(8'h1C);
      check("mk_latency", 32'(ev_empty), 32'd0);
      idle(5);
      send_byte(8'hF0);
      idle(5);
      send_byte(8'h1C);
      check("mb_count", 32'(ev_count), 32'd2);
      pop_check("mb_make", {2'b00, 8'h1C});
      pop_check("mb_break", {2'b01, 8'h1C});
      check("mb_empty", 32'(ev_empty), 32'd1);

      // Extended make / break, back-to-back strobes
      send_byte(8'hE0);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      check("ext_count", 32'(ev_count), 32'd2);
      pop_check("ext_make", {2'b10, 8'h75});
      pop_check("ext_break", {2'b11, 8'h75});

      // Housekeeping bytes discarded; FA cancels pending E0
      send_byte(8'hAA);
      send_byte(8'hFA);
      send_byte(8'hE0);
      send_byte(8'hFA);
      send_byte(8'h1C);
      check("disc_count", 32'(ev_count), 32'd1);
      pop_check("disc_ev", {2'b00, 8'h1C});
      check("disc_empty", 32'(ev_empty), 32'd1);

      // Timeout: next strobe 21 cycles after F0 -> plain make
      send_byte(8'hF0);
      idle(20);
      send_byte(8'h1C);
      pop_check("to_expired", {2'b00, 8'h1C});
      // 11 cycles -> still a break
      send_byte(8'hF0);
      idle(10);
      send_byte(8'h1C);
      pop_check("to_pending", {2'b01, 8'h1C});
      // Boundary: 15 cycles still pending, 17 cycles expired
      send_byte(8'hE0);
      idle(14);
      send_byte(8'h1C);
      pop_check("to_edge15", {2'b10, 8'h1C});
      send_byte(8'hE0);
      idle(16);
      send_byte(8'h1C);
      pop_check("to_edge17", {2'b00, 8'h1C});

      // FIFO overflow: 5 pushes, no reads
      send_byte(8'h15);
      send_byte(8'h16);
      send_byte(8'h1E);
      send_byte(8'h26);
      check("ff_full4", 32'(ev_full), 32'd1);
      check("ff_ovf_before", 32'(overflow), 32'd0);
      send_byte(8'h25);
      check("ff_count", 32'(ev_count), 32'd4);
      check("ff_ovf", 32'(overflow), 32'd1);
      pop_check("ff_pop0", {2'b00, 8'h15});
      pop_check("ff_pop1", {2'b00, 8'h16});
      pop_check("ff_pop2", {2'b00, 8'h1E});
      pop_check("ff_pop3", {2'b00, 8'h26});
      check("ff_empty", 32'(ev_empty), 32'd1);
      check("ff_ovf_sticky", 32'(overflow), 32'd1);
      do_reset();
      check("ff_ovf_clr", 32'(overflow), 32'd0);

      // Full with simultaneous push and pop: nothing dropped
      send_byte(8'h15);
      send_byte(8'h16);
      send_byte(8'h1E);
      send_byte(8'h26);
      ps2_data_out = 8'h25;
      pulso_done   = 1'b1;
      ev_rd        = 1'b1;
      @(negedge clk);
      pulso_done   = 1'b0;
      ev_rd        = 1'b0;
      check("fp_full", 32'(ev_full), 32'd1);
      check("fp_count", 32'(ev_count), 32'd4);
      check("fp_ovf", 32'(overflow), 32'd0);
      pop_check("fp_pop0", {2'b00, 8'h16});
      pop_check("fp_pop1", {2'b00, 8'h1E});
      pop_check("fp_pop2", {2'b00, 8'h26});
      pop_check("fp_pop3", {2'b00, 8'h25});
      check("fp_empty", 32'(ev_empty), 32'd1);

      // Pop request while empty with a push: only the push happens
      ps2_data_out = 8'h34;
      pulso_done   = 1'b1;
      ev_rd        = 1'b1;
      @(negedge clk);
      pulso_done   = 1'b0;
      ev_rd        = 1'b0;
      check("ep_count", 32'(ev_count), 32'd1);
      pop_check("ep_ev", {2'b00, 8'h34});

      // Reset mid-sequence, with a strobe during reset that must be ignored
      send_byte(8'hE0);
      reset        = 1'b1;
      ps2_data_out = 8'h33;
      pulso_done   = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      pulso_done   = 1'b0;
      check("mr_empty", 32'(ev_empty), 32'd1);
      check("mr_count", 32'(ev_count), 32'd0);
      send_byte(8'h6B);
      check("mr_count1", 32'(ev_count), 32'd1);
      pop_check("mr_ev", {2'b00, 8'h6B});
      check("mr_final_empty", 32'(ev_empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
